// File: rtl/lut_builder.sv
// lut_builder: latches four signed activations and fills a 16-entry subset-sum
// table, one entry per cycle. The table is then held until the consumer releases it.
// Entry k is the sum of a[i] over every i whose bit is set in k.
// Requires LUT_W >= ACT_W + 2 so the worst case, 4 * -2^(ACT_W-1), fits.
module lut_builder #(
  parameter int unsigned ACT_W = 8,
  parameter int unsigned LUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 act_valid_i,
  output logic                 act_ready_o,
  input  logic [4*ACT_W-1:0]   act_i,
  output logic                 lut_valid_o,
  input  logic                 lut_consume_i,
  output logic [16*LUT_W-1:0]  lut_o
);

  typedef enum logic [1:0] {StIdle, StBuild, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       k_q, k_d;
  logic             accept;
  logic [LUT_W-1:0] act_q [4];
  logic [LUT_W-1:0] lut_q [16];

  logic [3:0]       src_idx;
  logic [1:0]       act_sel;
  logic [LUT_W-1:0] build_sum;

  // Next-state and index-counter logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (act_valid_i) begin
          accept  = 1'b1;
          k_d     = 4'd1;
          state_d = StBuild;
        end
      end
      StBuild: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) state_d = StDone;
      end
      StDone: begin
        if (lut_consume_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Build datapath: clearing the lowest set bit of k gives an entry written earlier,
  // and that bit's position selects the activation to add.
  always_comb begin
    src_idx = k_q & (k_q - 4'd1);
    if (k_q[0])      act_sel = 2'd0;
    else if (k_q[1]) act_sel = 2'd1;
    else if (k_q[2]) act_sel = 2'd2;
    else             act_sel = 2'd3;
    build_sum = lut_q[src_idx] + act_q[act_sel];
  end

  // State, counter, latched activations and table storage
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      k_q     <= 4'd0;
      for (int i = 0; i < 4; i++) act_q[i] <= '0;
      for (int e = 0; e < 16; e++) lut_q[e] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (accept) begin
        for (int i = 0; i < 4; i++) begin
          act_q[i] <= {{(LUT_W - ACT_W){act_i[ACT_W*i + ACT_W - 1]}}, act_i[ACT_W*i +: ACT_W]};
        end
        lut_q[0] <= '0;
      end
      if (state_q == StBuild) lut_q[k_q] <= build_sum;
    end
  end

  // Outputs are pure decodes of state or a plain readout of the table
  always_comb begin
    act_ready_o = (state_q == StIdle);
    lut_valid_o = (state_q == StDone);
    for (int e = 0; e < 16; e++) lut_o[LUT_W*e +: LUT_W] = lut_q[e];
  end

endmodule
